// File: rtl/hex_display_scan_if.sv
// Display bus between the counter datapath and the multiplexed 7-segment driver.
// The datapath side (master) supplies value/flag requests; the driver side (slave) returns pin levels.
interface hex_display_scan_if #(
    parameter int DIGITS = 4
);
    logic                  _enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blink_in;
    logic                  lzb_in;
    logic [6:0]            segments_out;
    logic                  dp_out;
    logic [DIGITS-1:0]     digit_sel_n;
    logic                  frame_tick;

    modport master (
        output _enable, load, value_in, dp_in, blink_in, lzb_in,
        input  segments_out, dp_out, digit_sel_n, frame_tick
    );

    modport slave (
        input  _enable, load, value_in, dp_in, blink_in, lzb_in,
        output segments_out, dp_out, digit_sel_n, frame_tick
    );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed common-anode hex display driver: round-robin digit scan,
// 0-F glyph decode, per-digit dp/blink, leading-zero blanking and anode dead time.
// New values are staged in pending registers and only made active at a frame boundary.
module hex_display_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 2,
    parameter int BLINK_DIV   = 64
) (
    input  logic             clk,
    input  logic             reset,
    hex_display_scan_if.slave bus
);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] DEAD_V   = SLOT_W'(DEAD);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_MAX  = FRM_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FRM_W-1:0]        r_frame_cnt;
    logic                    r_blink_ph;
    logic [4*DIGITS-1:0]     r_act_val, r_pend_val;
    logic [DIGITS-1:0]       r_act_dp,  r_pend_dp;
    logic [DIGITS-1:0]       r_act_blk, r_pend_blk;
    logic                    r_pend_flag;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [DIGITS-1:0]       r_sel_n;
    logic                    r_frame_tick;

    logic                    w_slot_wrap;
    logic                    w_frame_end;
    logic [3:0]              w_nib;
    logic                    w_dp_req;
    logic                    w_blk_req;
    logic                    w_lz;
    logic [DIGITS:0]         w_zero_from;
    logic                    w_blank_blink;
    logic                    w_blank;
    logic [DIGITS-1:0]       w_sel_n;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        case (n)
            4'h0: f_glyph = 7'h01;  4'h1: f_glyph = 7'h4F;
            4'h2: f_glyph = 7'h12;  4'h3: f_glyph = 7'h06;
            4'h4: f_glyph = 7'h4C;  4'h5: f_glyph = 7'h24;
            4'h6: f_glyph = 7'h20;  4'h7: f_glyph = 7'h0F;
            4'h8: f_glyph = 7'h00;  4'h9: f_glyph = 7'h04;
            4'hA: f_glyph = 7'h08;  4'hB: f_glyph = 7'h60;
            4'hC: f_glyph = 7'h31;  4'hD: f_glyph = 7'h42;
            4'hE: f_glyph = 7'h30;  default: f_glyph = 7'h38;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot_cnt == SLOT_MAX);
    assign w_frame_end = w_slot_wrap && (r_idx == IDX_MAX);

    // Select the current digit's fields and find whether it sits in the run of leading zeros
    always_comb begin
        w_nib       = 4'h0;
        w_dp_req    = 1'b0;
        w_blk_req   = 1'b0;
        w_lz        = 1'b0;
        w_zero_from = '0;
        w_sel_n     = '1;
        w_zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--)
            w_zero_from[k] = w_zero_from[k+1] & (r_act_val[4*k +: 4] == 4'h0);
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib     = r_act_val[4*k +: 4];
                w_dp_req  = r_act_dp[k];
                w_blk_req = r_act_blk[k];
                w_lz      = (k != 0) && w_zero_from[k];
                if (r_slot_cnt >= DEAD_V)
                    w_sel_n[k] = 1'b0;
            end
        end
        w_blank_blink = r_blink_ph & w_blk_req;
        w_blank       = w_blank_blink | (bus.lzb_in & w_lz);
    end

    // Slot/digit/frame/blink counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
            if (w_slot_wrap)
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            if (w_frame_end) begin
                if (r_frame_cnt == FRM_MAX) begin
                    r_frame_cnt <= '0;
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Pending/active double buffer; a load on the boundary cycle waits for the next boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_val   <= '0;
            r_act_dp    <= '0;
            r_act_blk   <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_blk  <= '0;
            r_pend_flag <= 1'b0;
        end else begin
            if (w_frame_end && r_pend_flag) begin
                r_act_val   <= r_pend_val;
                r_act_dp    <= r_pend_dp;
                r_act_blk   <= r_pend_blk;
                r_pend_flag <= 1'b0;
            end
            if (bus.load) begin
                r_pend_val  <= bus.value_in;
                r_pend_dp   <= bus.dp_in;
                r_pend_blk  <= bus.blink_in;
                r_pend_flag <= 1'b1;
            end
        end
    end

    // Registered pin drive; disable only darkens the pins, scanning continues underneath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_sel_n      <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (bus._enable) begin
                r_seg   <= 7'h7F;
                r_dp    <= 1'b1;
                r_sel_n <= '1;
            end else begin
                r_seg   <= w_blank ? 7'h7F : f_glyph(w_nib);
                r_dp    <= w_blank_blink ? 1'b1 : ~w_dp_req;
                r_sel_n <= w_sel_n;
            end
        end
    end

    assign bus.segments_out = r_seg;
    assign bus.dp_out       = r_dp;
    assign bus.digit_sel_n  = r_sel_n;
    assign bus.frame_tick   = r_frame_tick;
endmodule
